// File: rtl/jk_ff_driver.sv
// Sequencing initiator for a jk_ff: queues target Q bits, drives the J/K excitation
// for one cycle, then checks the flip-flop's q against the tracked expectation.
module jk_ff_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CW      = 8,
    parameter int unsigned DC_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    output logic          j,
    output logic          k,
    input  logic          q_fb,
    output logic          chk_valid,
    output logic          chk_ok,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    output logic          busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = AW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    // StInit is the reset state; the flip-flop sees the forcing 0,1 during StInitDrv.
    typedef enum logic [2:0] {
        StInit, StInitDrv, StInitChk, StIdle, StDrive, StCheck
    } state_e;

    state_e          r_state;
    logic            r_j, r_k, r_q_exp;
    logic            r_chk_valid, r_chk_ok, r_err, r_busy, r_in_ready;
    logic [CW-1:0]   r_err_cnt;
    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic            w_push, w_pop, w_empty, w_head, w_match;
    logic [CntW-1:0] w_count_d;

    function automatic logic [1:0] f_exc(input logic q, input logic t);
        if (DC_MODE != 0) return {q | t, ~(q & t)};
        return {~q & t, q & ~t};
    endfunction

    assign w_empty = (r_count == '0);
    assign w_push  = in_valid & r_in_ready;
    assign w_pop   = ((r_state == StIdle) || (r_state == StCheck)) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_match = (q_fb == r_q_exp);

    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_d;
            r_in_ready <= (w_count_d != FullCnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StInit;
            r_j         <= 1'b0;
            r_k         <= 1'b0;
            r_q_exp     <= 1'b0;
            r_chk_valid <= 1'b0;
            r_chk_ok    <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_busy      <= 1'b1;
        end else begin
            r_chk_valid <= 1'b0;
            r_j         <= 1'b0;
            r_k         <= 1'b0;
            r_busy      <= 1'b1;
            case (r_state)
                StInit: begin
                    r_k     <= 1'b1;
                    r_q_exp <= 1'b0;
                    r_state <= StInitDrv;
                end
                StInitDrv: r_state <= StInitChk;
                StInitChk, StCheck: begin
                    r_chk_valid <= 1'b1;
                    r_chk_ok    <= w_match;
                    // q_exp is deliberately left alone on a mismatch.
                    if (!w_match) begin
                        r_err <= 1'b1;
                        if (r_err_cnt != {CW{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    if ((r_state == StCheck) && w_pop) begin
                        {r_j, r_k} <= f_exc(r_q_exp, w_head);
                        r_q_exp    <= w_head;
                        r_state    <= StDrive;
                    end else begin
                        r_busy  <= (w_count_d != '0);
                        r_state <= StIdle;
                    end
                end
                StIdle: begin
                    if (w_pop) begin
                        {r_j, r_k} <= f_exc(r_q_exp, w_head);
                        r_q_exp    <= w_head;
                        r_state    <= StDrive;
                    end else begin
                        r_busy <= (w_count_d != '0);
                    end
                end
                StDrive: r_state <= StCheck;
                default: r_state <= StInit;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign j         = r_j;
    assign k         = r_k;
    assign chk_valid = r_chk_valid;
    assign chk_ok    = r_chk_ok;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_jk_ff_driver.sv
// Directed bench for jk_ff_driver: three instances (DC_MODE 0, DC_MODE 1, CW=2),
// each closed around a behavioural jk flip-flop whose q can be forced to 0.
module tb_jk_ff_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n = '0, in_valid = '0, in_bit = '0, force0 = '0;
    logic [2:0] in_ready, j, k, chk_valid, chk_ok, err, busy, q_fb;
    logic [7:0] err_cnt0, err_cnt1;
    logic [1:0] err_cnt2;
    logic [2:0] q_m = 3'b111;
    int total = 0;
    int bad = 0;

    assign q_fb = q_m & ~force0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            case ({j[i], k[i]})
                2'b01:   q_m[i] <= 1'b0;
                2'b10:   q_m[i] <= 1'b1;
                2'b11:   q_m[i] <= ~q_m[i];
                default: ;
            endcase
        end
    end

    jk_ff_driver #(.DEPTH(4), .CW(8), .DC_MODE(0)) u_dc0 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_bit(in_bit[0]),
        .in_ready(in_ready[0]), .j(j[0]), .k(k[0]), .q_fb(q_fb[0]),
        .chk_valid(chk_valid[0]), .chk_ok(chk_ok[0]), .err(err[0]), .err_cnt(err_cnt0),
        .busy(busy[0])
    );
    jk_ff_driver #(.DEPTH(4), .CW(8), .DC_MODE(1)) u_dc1 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_bit(in_bit[1]),
        .in_ready(in_ready[1]), .j(j[1]), .k(k[1]), .q_fb(q_fb[1]),
        .chk_valid(chk_valid[1]), .chk_ok(chk_ok[1]), .err(err[1]), .err_cnt(err_cnt1),
        .busy(busy[1])
    );
    jk_ff_driver #(.DEPTH(4), .CW(2), .DC_MODE(0)) u_sat (
        .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_bit(in_bit[2]),
        .in_ready(in_ready[2]), .j(j[2]), .k(k[2]), .q_fb(q_fb[2]),
        .chk_valid(chk_valid[2]), .chk_ok(chk_ok[2]), .err(err[2]), .err_cnt(err_cnt2),
        .busy(busy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt_of(input int d);
        if (d == 0) return err_cnt0;
        if (d == 1) return err_cnt1;
        return {6'd0, err_cnt2};
    endfunction

    // Release reset and walk the three init edges.
    task automatic release_init(input int d);
        rst_n[d] = 1'b1;
        step();
        chk("init_jk01", {j[d], k[d]}, 2'b01);
        chk("init_ready", in_ready[d], 1'b1);
        chk("init_cv0", chk_valid[d], 1'b0);
        step();
        chk("init_jk00", {j[d], k[d]}, 2'b00);
        step();
        chk("init_cv", chk_valid[d], 1'b1);
        chk("init_ok", chk_ok[d], 1'b1);
        chk("init_err", err[d], 1'b0);
        chk("init_cnt", cnt_of(d), 8'd0);
        chk("init_busy", busy[d], 1'b0);
    endtask

    // Push n bits on consecutive edges from IDLE; drives land on even edges, checks from edge 4.
    task automatic stream(input int d, input logic [4:0] bits, input int n,
                          input logic [9:0] exp_jk, input logic [4:0] exp_ok, input string tag);
        for (int r = 1; r <= 2 * n + 2; r++) begin
            in_valid[d] = (r <= n);
            in_bit[d]   = (r <= n) ? bits[r-1] : 1'b0;
            step();
            if ((r % 2 == 0) && (r <= 2 * n)) chk({tag, "_jk"}, {j[d], k[d]}, exp_jk[r-2 +: 2]);
            if ((r >= 4) && (r % 2 == 0)) begin
                chk({tag, "_cv"}, chk_valid[d], 1'b1);
                chk({tag, "_ok"}, chk_ok[d], exp_ok[r/2-2]);
            end else begin
                chk({tag, "_cv0"}, chk_valid[d], 1'b0);
            end
        end
        chk({tag, "_busy"}, busy[d], 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [5:0] fbits;
        logic       sb[$];
        logic       acc, b, exp_b;
        logic [2:0] idx;
        int         acc_n, nchk;

        repeat (3) step();
        chk("rst_j", j[0], 1'b0);
        chk("rst_k", k[0], 1'b0);
        chk("rst_ready", in_ready[0], 1'b0);
        chk("rst_cv", chk_valid[0], 1'b0);
        chk("rst_ok", chk_ok[0], 1'b0);
        chk("rst_err", err[0], 1'b0);
        chk("rst_cnt", err_cnt0, 8'd0);
        chk("rst_busy", busy[0], 1'b1);

        release_init(0);
        stream(0, 5'b10011, 5, 10'b10_00_01_00_10, 5'b11111, "dc0");
        chk("dc0_err", err[0], 1'b0);

        release_init(1);
        stream(1, 5'b10011, 5, 10'b11_01_11_10_11, 5'b11111, "dc1");
        chk("dc1_err", err[1], 1'b0);

        // Stuck-at-0 feedback: expectation keeps tracking the targets.
        rst_n[0]  = 1'b0;
        force0[0] = 1'b1;
        step();
        release_init(0);
        stream(0, 5'b00111, 3, 10'b00_00_00_00_10, 5'b00000, "flt");
        chk("flt_err", err[0], 1'b1);
        chk("flt_cnt", err_cnt0, 8'd3);

        force0[2] = 1'b1;
        release_init(2);
        stream(2, 5'b11111, 5, 10'b00_00_00_00_10, 5'b00000, "sat");
        chk("sat_err", err[2], 1'b1);
        chk("sat_cnt", err_cnt2, 2'd3);

        // FIFO fill: in_valid held from reset release; scoreboard checks order.
        force0[0] = 1'b0;
        rst_n[0]  = 1'b0;
        step();
        pat   = 8'b1011_0010;
        sb    = {1'b0};
        acc_n = 0;
        nchk  = 0;
        in_valid[0] = 1'b1;
        in_bit[0]   = pat[0];
        rst_n[0]    = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            acc = in_valid[0] & in_ready[0];
            b   = in_bit[0];
            step();
            if (acc) begin
                sb.push_back(b);
                acc_n++;
            end
            idx = acc_n[2:0];
            in_valid[0] = (acc_n < 8);
            in_bit[0]   = (acc_n < 8) ? pat[idx] : 1'b0;
            if (c == 1) chk("fill_jk01", {j[0], k[0]}, 2'b01);
            if (c == 7) chk("fill_full", in_ready[0], 1'b0);
            if (c == 8) chk("fill_popfull", in_ready[0], 1'b1);
            if (chk_valid[0]) begin
                nchk++;
                chk("fill_sb", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    chk("fill_order", q_m[0], exp_b);
                end
                chk("fill_ok", chk_ok[0], 1'b1);
            end
        end
        chk("fill_nchk", nchk, 9);
        chk("fill_acc", acc_n, 8);
        chk("fill_busy", busy[0], 1'b0);

        // Reset asserted mid-DRIVE with three targets still queued.
        fbits = 6'b111010;
        for (int r = 1; r <= 6; r++) begin
            in_valid[0] = 1'b1;
            in_bit[0]   = fbits[r-1];
            step();
        end
        in_valid[0] = 1'b0;
        chk("mid_jk", {j[0], k[0]}, 2'b01);
        chk("mid_busy", busy[0], 1'b1);
        rst_n[0] = 1'b0;
        #1;
        chk("mid_rst_jk", {j[0], k[0]}, 2'b00);
        chk("mid_rst_ready", in_ready[0], 1'b0);
        chk("mid_rst_busy", busy[0], 1'b1);
        chk("mid_rst_cv", chk_valid[0], 1'b0);
        step();
        step();
        release_init(0);
        for (int r = 0; r < 4; r++) begin
            step();
            chk("stale_jk", {j[0], k[0]}, 2'b00);
            chk("stale_cv", chk_valid[0], 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
